// File: rtl/pantalla_top_if.sv
// Serial display bus: UART line into the receiver, LED pattern back out.
interface pantalla_top_if;
    logic       rxM;
    logic [7:0] leds;

    modport master (output rxM, input leds);
    modport slave  (input rxM, output leds);
endinterface

// File: rtl/pantalla_top.sv
// 8N1 UART receiver that shows the last correctly framed byte on eight LEDs.
module pantalla_top #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic          clkM,
    input  logic          rstM,
    pantalla_top_if.slave bus
);

    localparam int unsigned CntW = ($clog2(CLKS_PER_BIT) > 9) ? $clog2(CLKS_PER_BIT) : 9;
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      leds_q, leds_d;
    logic            rx_meta, rx_s;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clkM) begin
        if (rstM) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rxM;
            rx_s    <= rx_meta;
        end
    end

    // State, counters, shift register and LED register.
    always_ff @(posedge clkM) begin
        if (rstM) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            leds_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            leds_q    <= leds_d;
        end
    end

    // Next-state logic: mid-bit sampling driven by the bit counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        leds_d    = leds_q;

        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end

            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    // A high line at mid-start means the edge was a glitch.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    // LSB first: after eight shifts the first bit sits in bit 0.
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        leds_d  = shift_q;
                        state_d = StIdle;
                    end else begin
                        // Framing error: drop the byte and wait out any break.
                        state_d = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StWaitHigh: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.leds = leds_q;

endmodule

// File: tb/tb_pantalla_top.sv
// Directed bench for the UART-to-LED receiver.
module tb_pantalla_top;

    localparam int Bit = 434;
    // Offsets into the stop bit straddling the mid-stop sample (~219 clocks in).
    localparam int PreMid  = 200;
    localparam int PostMid = Bit - PreMid;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    pantalla_top_if bus ();

    pantalla_top #(
        .CLKS_PER_BIT(434),
        .HALF_BIT    (217)
    ) dut (
        .clkM(clk),
        .rstM(rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start bit, eight data bits, then the stop level held up to just before mid-stop.
    task automatic frame_to_pre(input logic [7:0] data, input logic stop);
        bus.rxM = 1'b0;
        wait_clks(Bit);
        for (int i = 0; i < 8; i++) begin
            bus.rxM = data[i];
            wait_clks(Bit);
        end
        bus.rxM = stop;
        wait_clks(PreMid);
    endtask

    // Remainder of the stop bit; the line is left at the stop level.
    task automatic frame_finish();
        wait_clks(PostMid);
    endtask

    task automatic test_reset();
        bus.rxM = 1'b1;
        rst = 1'b1;
        wait_clks(5);
        rst = 1'b0;
        n_vec++;
        if (bus.leds !== 8'h00) begin
            $display("FAIL reset_leds: got %h want %h", bus.leds, 8'h00);
            n_bad++;
        end
        wait_clks(300);
        n_vec++;
        if (bus.leds !== 8'h00) begin
            $display("FAIL reset_idle_hold: got %h want %h", bus.leds, 8'h00);
            n_bad++;
        end
    endtask

    task automatic test_single_frame();
        #100;
        @(negedge clk);
        frame_to_pre(8'h5B, 1'b1);
        n_vec++;
        if (bus.leds !== 8'h00) begin
            $display("FAIL single_pre_mid: got %h want %h", bus.leds, 8'h00);
            n_bad++;
        end
        wait_clks(30);
        n_vec++;
        if (bus.leds !== 8'h5B) begin
            $display("FAIL single_post_mid: got %h want %h", bus.leds, 8'h5B);
            n_bad++;
        end
        wait_clks(PostMid - 30);
        wait_clks(500);
        n_vec++;
        if (bus.leds !== 8'h5B) begin
            $display("FAIL single_stable: got %h want %h", bus.leds, 8'h5B);
            n_bad++;
        end
    endtask

    task automatic test_back_to_back();
        frame_to_pre(8'hA5, 1'b1);
        n_vec++;
        if (bus.leds !== 8'h5B) begin
            $display("FAIL b2b_first_pre: got %h want %h", bus.leds, 8'h5B);
            n_bad++;
        end
        frame_finish();
        n_vec++;
        if (bus.leds !== 8'hA5) begin
            $display("FAIL b2b_first: got %h want %h", bus.leds, 8'hA5);
            n_bad++;
        end
        frame_to_pre(8'h3C, 1'b1);
        n_vec++;
        if (bus.leds !== 8'hA5) begin
            $display("FAIL b2b_second_pre: got %h want %h", bus.leds, 8'hA5);
            n_bad++;
        end
        frame_finish();
        n_vec++;
        if (bus.leds !== 8'h3C) begin
            $display("FAIL b2b_second: got %h want %h", bus.leds, 8'h3C);
            n_bad++;
        end
    endtask

    task automatic test_glitch();
        bus.rxM = 1'b0;
        wait_clks(100);
        bus.rxM = 1'b1;
        wait_clks(1000);
        n_vec++;
        if (bus.leds !== 8'h3C) begin
            $display("FAIL glitch_hold: got %h want %h", bus.leds, 8'h3C);
            n_bad++;
        end
        frame_to_pre(8'h81, 1'b1);
        frame_finish();
        n_vec++;
        if (bus.leds !== 8'h81) begin
            $display("FAIL glitch_next_frame: got %h want %h", bus.leds, 8'h81);
            n_bad++;
        end
    endtask

    task automatic test_framing_error();
        frame_to_pre(8'hFF, 1'b0);
        frame_finish();
        n_vec++;
        if (bus.leds !== 8'h81) begin
            $display("FAIL framing_bad_stop: got %h want %h", bus.leds, 8'h81);
            n_bad++;
        end
        wait_clks(2 * Bit);
        n_vec++;
        if (bus.leds !== 8'h81) begin
            $display("FAIL framing_break: got %h want %h", bus.leds, 8'h81);
            n_bad++;
        end
        bus.rxM = 1'b1;
        wait_clks(Bit);
        n_vec++;
        if (bus.leds !== 8'h81) begin
            $display("FAIL framing_recover_idle: got %h want %h", bus.leds, 8'h81);
            n_bad++;
        end
        frame_to_pre(8'h12, 1'b1);
        frame_finish();
        n_vec++;
        if (bus.leds !== 8'h12) begin
            $display("FAIL framing_next_frame: got %h want %h", bus.leds, 8'h12);
            n_bad++;
        end
    endtask

    task automatic test_reset_mid_frame();
        // Upper nibble high so the post-reset remainder cannot look like a start bit.
        logic [7:0] data;
        data = 8'hF3;
        bus.rxM = 1'b0;
        wait_clks(Bit);
        for (int i = 0; i < 4; i++) begin
            bus.rxM = data[i];
            wait_clks(Bit);
        end
        bus.rxM = data[4];
        wait_clks(PreMid);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        n_vec++;
        if (bus.leds !== 8'h00) begin
            $display("FAIL midreset_leds: got %h want %h", bus.leds, 8'h00);
            n_bad++;
        end
        wait_clks(Bit - PreMid - 1);
        for (int i = 5; i < 8; i++) begin
            bus.rxM = data[i];
            wait_clks(Bit);
        end
        bus.rxM = 1'b1;
        wait_clks(2 * Bit);
        n_vec++;
        if (bus.leds !== 8'h00) begin
            $display("FAIL midreset_truncated: got %h want %h", bus.leds, 8'h00);
            n_bad++;
        end
        frame_to_pre(8'h77, 1'b1);
        frame_finish();
        n_vec++;
        if (bus.leds !== 8'h77) begin
            $display("FAIL midreset_next_frame: got %h want %h", bus.leds, 8'h77);
            n_bad++;
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.rxM = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
